// File: rtl/gain_restore_pkg.sv
// Shared types and constants for the gain_restore block: FSM states, unity gain,
// default gain format and the signed saturation limits.
package gain_restore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [15:0] UNITY_GAIN    = 16'h0800;
    localparam int          GAIN_FRAC_DEF = 11;
    localparam int          DATA_W_DEF    = 8;

    // Largest positive magnitude representable in a signed w-bit sample.
    function automatic int sat_pos_mag(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Largest negative magnitude representable in a signed w-bit sample.
    function automatic int sat_neg_mag(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/gain_restore_udiv.sv
// Serial restoring unsigned divider: loads operands on start, then produces one
// quotient bit per cycle for N_W cycles; done flags the final quotient for one cycle.
module serial_udiv #(
    parameter int N_W = 19,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int CNT_W = $clog2(N_W + 1);

    logic [N_W-1:0]   quo;
    logic [D_W-1:0]   rem;
    logic [D_W-1:0]   dvs;
    logic [CNT_W-1:0] cnt;
    logic [D_W:0]     trial;
    logic             take;

    // The partial remainder is always below the divisor, so the subtraction
    // can be done modulo 2^D_W once the compare says it fits.
    assign trial = {rem, quo[N_W-1]};
    assign take  = trial >= {1'b0, dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            quo  <= dividend;
            rem  <= '0;
            dvs  <= divisor;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == CNT_W'(N_W)) begin
                busy <= 1'b0;
            end else begin
                rem <= take ? (trial[D_W-1:0] - dvs) : trial[D_W-1:0];
                quo <= {quo[N_W-2:0], take};
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done     = busy && (cnt == CNT_W'(N_W));
    assign quotient = quo;

endmodule

// File: rtl/gain_restore.sv
// Restores a gain-normalised sample: out = sign(x) * |x| / gain (Q5.11), saturated.
// Optional macro GAIN_RESTORE_ROUND_EN rounds half-away-from-zero instead of truncating.
module gain_restore
    import gain_restore_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int GAIN_FRAC = GAIN_FRAC_DEF
) (
    input  logic                     clk,
    input  logic                     reset_x,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              gain_in,
    input  logic                     gain_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     ovf
);

`ifdef GAIN_RESTORE_ROUND_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif
    localparam int Q_W = DATA_W + GAIN_FRAC + XTRA;
    localparam int SH  = GAIN_FRAC + XTRA;

    localparam logic [Q_W-1:0]           POS_LIM = Q_W'(sat_pos_mag(DATA_W));
    localparam logic [Q_W-1:0]           NEG_LIM = Q_W'(sat_neg_mag(DATA_W));
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   state, state_nx;
    logic [15:0]              gain_q;
    logic [15:0]              divisor_sel;
    logic                     neg_p0, zero_p0;
    logic [DATA_W-1:0]        abs_mag;
    logic [Q_W-1:0]           dividend, quotient, mag;
    logic                     start, div_busy, div_done;
    logic [DATA_W:0]          sat_res;

    // Returns {ovf, sample}; a negative result may reach one count further than a positive one.
    function automatic logic [DATA_W:0] saturate(input logic neg, input logic [Q_W-1:0] m);
        logic [DATA_W-1:0] low;
        low = m[DATA_W-1:0];
        if (neg)
            return (m > NEG_LIM) ? {1'b1, OUT_MIN} : {1'b0, DATA_W'(-low)};
        else
            return (m > POS_LIM) ? {1'b1, OUT_MAX} : {1'b0, low};
    endfunction

    // |x| fits in DATA_W unsigned bits, including the most negative input.
    assign abs_mag     = in_sample[DATA_W-1] ? DATA_W'(-in_sample) : DATA_W'(in_sample);
    assign dividend    = {abs_mag, {SH{1'b0}}};
    assign divisor_sel = gain_valid ? gain_in : gain_q;

`ifdef GAIN_RESTORE_ROUND_EN
    assign mag = {1'b0, quotient[Q_W-1:1]} + Q_W'(quotient[0]);
`else
    assign mag = quotient;
`endif

    always_comb begin
        sat_res = saturate(neg_p0, mag);
        if (zero_p0)
            sat_res = {1'b1, (neg_p0 ? OUT_MIN : OUT_MAX)};
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !div_busy;
                start    = in_valid && !div_busy;
                if (start) state_nx = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) state_nx = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            state      <= ST_IDLE;
            gain_q     <= UNITY_GAIN;
            neg_p0     <= 1'b0;
            zero_p0    <= 1'b0;
            out_sample <= '0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nx;
            if (gain_valid) gain_q <= gain_in;
            // Acceptance: sign and zero-gain flag travel with the sample into the divider
            if (start) begin
                neg_p0  <= in_sample[DATA_W-1];
                zero_p0 <= (divisor_sel == 16'd0);
            end
            // Division complete: register the saturated result for the OUT state
            if (state == ST_DIV && div_done)
                {ovf, out_sample} <= sat_res;
        end
    end

    serial_udiv #(
        .N_W (Q_W),
        .D_W (16)
    ) u_div (
        .clk      (clk),
        .rst      (reset_x),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor_sel),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

endmodule

// File: tb/tb_gain_restore.sv
// Directed testbench for gain_restore with hand-computed expected results.
module tb_gain_restore;

`ifdef GAIN_RESTORE_ROUND_EN
    localparam int LAT = 21;
    localparam logic signed [7:0] EXP_101_D2 = 8'sd51;
    localparam logic signed [7:0] EXP_M8_D3  = -8'sd3;
`else
    localparam int LAT = 20;
    localparam logic signed [7:0] EXP_101_D2 = 8'sd50;
    localparam logic signed [7:0] EXP_M8_D3  = -8'sd2;
`endif

    logic              clk = 1'b0;
    logic              reset_x;
    logic signed [7:0] in_sample;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       gain_in;
    logic              gain_valid;
    logic signed [7:0] out_sample;
    logic              out_valid;
    logic              out_ready;
    logic              ovf;

    int cyc = 0;
    int acc_cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    gain_restore dut (
        .clk        (clk),
        .reset_x    (reset_x),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .gain_in    (gain_in),
        .gain_valid (gain_valid),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_gain(input logic [15:0] g);
        @(negedge clk);
        gain_in    = g;
        gain_valid = 1'b1;
        @(posedge clk);
        #1;
        gain_valid = 1'b0;
    endtask

    task automatic accept(input string tag, input logic signed [7:0] s);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        in_sample = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic signed [7:0] es, input logic eo);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, cyc - acc_cyc, LAT);
        chk({tag, "_sample"}, 32'(out_sample), 32'(es));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 0);
    endtask

    task automatic run(input string tag, input logic signed [7:0] s,
                       input logic signed [7:0] es, input logic eo);
        accept(tag, s);
        collect(tag, es, eo);
        release_out(tag);
    endtask

    initial begin
        int seen;
        reset_x    = 1'b1;
        in_sample  = '0;
        in_valid   = 1'b0;
        gain_in    = '0;
        gain_valid = 1'b0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_out_sample", 32'(out_sample), 0);
        @(negedge clk);
        reset_x = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        run("unity_100", 8'sd100, 8'sd100, 1'b0);
        run("unity_127", 8'sd127, 8'sd127, 1'b0);
        run("unity_m128", -8'sd128, -8'sd128, 1'b0);

        set_gain(16'h1000);
        run("g2_m100", -8'sd100, -8'sd50, 1'b0);
        run("g2_101", 8'sd101, EXP_101_D2, 1'b0);

        set_gain(16'h1800);
        run("g3_7", 8'sd7, 8'sd2, 1'b0);
        run("g3_m8", -8'sd8, EXP_M8_D3, 1'b0);

        set_gain(16'h0400);
        run("gh_100", 8'sd100, 8'sd127, 1'b1);
        run("gh_m128", -8'sd128, -8'sd128, 1'b1);
        run("gh_m64", -8'sd64, -8'sd128, 1'b0);
        run("gh_64", 8'sd64, 8'sd127, 1'b1);

        set_gain(16'h0000);
        run("g0_5", 8'sd5, 8'sd127, 1'b1);
        run("g0_m5", -8'sd5, -8'sd128, 1'b1);
        run("g0_0", 8'sd0, 8'sd127, 1'b1);

        // Gain change while a sample is in the divider
        set_gain(16'h0800);
        accept("mid_60", 8'sd60);
        repeat (4) @(posedge clk);
        set_gain(16'h1800);
        collect("mid_60", 8'sd60, 1'b0);
        release_out("mid_60");
        run("after_60", 8'sd60, 8'sd20, 1'b0);

        // Gain load coinciding with acceptance
        @(negedge clk);
        in_sample  = 8'sd40;
        in_valid   = 1'b1;
        gain_in    = 16'h1000;
        gain_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc    = cyc;
        in_valid   = 1'b0;
        gain_valid = 1'b0;
        collect("coinc_40", 8'sd20, 1'b0);
        release_out("coinc_40");

        // Output backpressure
        accept("stall", -8'sd90);
        collect("stall", -8'sd45, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_sample", 32'(out_sample), -45);
            chk("stall_ovf", 32'(ovf), 0);
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        release_out("stall");
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("stall_single_xfer", seen, 0);

        // Reset in the middle of a division
        accept("rst_mid", 8'sd100);
        repeat (7) @(posedge clk);
        #1;
        reset_x = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        reset_x = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("rst_mid_no_output", seen, 0);
        run("rst_mid_next", 8'sd100, 8'sd100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gain_restore.md
GAIN_RESTORE -- requirements
Module: gain_restore

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the signed sample width.
REQ-002 The block SHALL have parameter GAIN_FRAC, default 11, meaning the number of fractional bits of the unsigned 16-bit gain word (Q5.11).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_x  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port in_sample  input  DATA_W signed  gain-normalised sample to restore.
REQ-006 The block SHALL have port in_valid / in_ready  input / output  1 each  sample handshake; transfer occurs when both are high at a clock edge.
REQ-007 The block SHALL have port gain_in  input  16  applied gain (Q5.11) that was used on the sample stream.
REQ-008 The block SHALL have port gain_valid  input  1  loads gain_in into the gain register.
REQ-009 The block SHALL have port out_sample  output  DATA_W signed  restored sample.
REQ-010 The block SHALL have port out_valid / out_ready  output / input  1 each  result handshake.
REQ-011 The block SHALL have port ovf  output  1  saturation flag, qualified by out_valid.

Function
REQ-012 The block SHALL compute out_sample = sign(in_sample) * floor((|in_sample| << GAIN_FRAC) / gain), with |in_sample| taken in DATA_W+1 bits so -128 gives 128.
REQ-013 The FSM SHALL have states IDLE (in_ready=1), DIV (iterating), OUT (out_valid=1); IDLE->DIV on transfer, DIV->OUT after the last iteration, OUT->IDLE when out_ready=1.
REQ-014 The divider SHALL be serial restoring, one quotient bit per cycle, DATA_W+GAIN_FRAC iterations (19 by default), with a 19-bit dividend and a 16-bit divisor.
REQ-015 out_valid SHALL rise on the 20th rising edge after the accepting edge (default widths, macro absent).
REQ-016 On gain_valid=1 the gain register SHALL load at that edge; the divisor SHALL be snapshotted at sample acceptance, so a gain change mid-division SHALL NOT affect the sample in flight.
REQ-017 If gain_valid and the input transfer coincide, the accepted sample SHALL use the new gain_in.
REQ-018 If the quotient magnitude exceeds 127 (positive) or 128 (negative), the output SHALL saturate to +127 / -128 with ovf=1; otherwise ovf=0.
REQ-019 A gain of zero SHALL skip division and give saturation at sign(in_sample) (+127 for 0 or positive input) with ovf=1, keeping the same latency.
REQ-020 out_sample, out_valid and ovf SHALL hold stable in OUT until out_ready=1; in_ready SHALL be 0 outside IDLE.

Reset
REQ-021 With reset_x=1, the block SHALL asynchronously go to state IDLE with out_sample=0, out_valid=0, ovf=0, in_ready=1 (after release), gain register=0x0800 (1.0), and divider registers at 0.
REQ-022 A reset during DIV or OUT SHALL discard the in-flight sample with no output produced.

Configuration
REQ-023 When macro GAIN_RESTORE_ROUND_EN is defined, the block SHALL compute one extra quotient bit (20 iterations, out_valid on the 21st edge) and round the magnitude half-away-from-zero before saturation.
REQ-024 When GAIN_RESTORE_ROUND_EN is not defined, the magnitude SHALL truncate toward zero.

Structure
REQ-025 The shared package SHALL hold the FSM state enum, the unity-gain constant 0x0800, the GAIN_FRAC default, and the saturation limits.
REQ-026 The serial divider SHALL be a separate sub-module serial_udiv (start/busy/done, unsigned quotient); the FSM, sign handling and saturation SHALL stay in gain_restore.

Verification
REQ-027 Scenario: gain 0x0800, in_sample 100 -> out_sample 100, ovf=0, out_valid exactly 20 edges after acceptance.
REQ-028 Scenario: gain 0x1000, in_sample -100 -> -50; in_sample 101 -> 50 (truncation) or 51 (with GAIN_RESTORE_ROUND_EN).
REQ-029 Scenario: gain 0x0400, in_sample 100 -> +127, ovf=1; in_sample -128 -> -128, ovf=1; gain 0, in_sample 5 -> +127, ovf=1.
REQ-030 Scenario: gain 0x1800 loaded via gain_valid mid-division -> the in-flight sample (60, gain 0x0800) gives 60; the next sample 60 gives 20.
REQ-031 Scenario: out_ready held low 10 cycles -> out_sample/ovf stable, in_ready=0 throughout, and exactly one transfer when out_ready=1.
REQ-032 Scenario: reset_x pulsed at iteration 7 -> out_valid=0 immediately, no output emitted, gain=0x0800, and the next sample is processed normally.
